// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer between PC and decoder
// Fetches opcode (and operand for long-format opcodes) and presents the instruction.
module fetch_unit #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int LONG_OP_BIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              halt,
  input  logic              flush,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand
);

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_ARG  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic                accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_OP;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  // An opcode request already on the bus survives a late halt; halt only blocks new starts.
  always_comb begin
    mem_req = 1'b0;
    case (state_q)
      S_OP:    mem_req = ~flush & (~halt | pend_q);
      S_ARG:   mem_req = ~flush;
      default: mem_req = 1'b0;
    endcase
    if (reset) mem_req = 1'b0;
    accept   = mem_req & mem_ack;
    pc_inc   = accept;
    mem_addr = pc;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_OP;
    end else begin
      case (state_q)
        S_OP:    if (accept) state_d = mem_rdata[LONG_OP_BIT] ? S_ARG : S_HOLD;
        S_ARG:   if (accept) state_d = S_HOLD;
        S_HOLD:  if (instr_ready) state_d = S_OP;
        default: state_d = S_OP;
      endcase
    end
  end

  always_comb begin
    pend_d    = (state_q == S_OP) & mem_req & ~mem_ack;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    if (flush) begin
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_OP: if (accept) begin
          opcode_d  = mem_rdata;
          operand_d = '0;
          valid_d   = ~mem_rdata[LONG_OP_BIT];
        end
        S_ARG: if (accept) begin
          operand_d = mem_rdata;
          valid_d   = 1'b1;
        end
        S_HOLD: if (instr_ready) valid_d = 1'b0;
        default: valid_d = 1'b0;
      endcase
    end
  end

  assign instr_valid   = valid_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic       pc_inc;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       halt;
  logic       flush;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.DATA_W(8), .ADDR_W(8), .LONG_OP_BIT(7)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_inc(pc_inc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halt(halt), .flush(flush), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
    halt = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    #2;
    chk("rst_valid", {7'd0, instr_valid}, 8'h0);
    chk("rst_opcode", instr_opcode, 8'h00);
    chk("rst_operand", instr_operand, 8'h00);
    chk("rst_req", {7'd0, mem_req}, 8'h0);
    chk("rst_inc", {7'd0, pc_inc}, 8'h0);
    tick();
    reset = 1'b0;

    // 1: one-byte opcode, zero-wait memory
    pc = 8'h00; mem_rdata = 8'h12; mem_ack = 1'b1; #1;
    chk("t1_req", {7'd0, mem_req}, 8'h1);
    chk("t1_inc", {7'd0, pc_inc}, 8'h1);
    chk("t1_addr", mem_addr, 8'h00);
    chk("t1_valid0", {7'd0, instr_valid}, 8'h0);
    tick();
    pc = 8'h01; #1;
    chk("t1_valid1", {7'd0, instr_valid}, 8'h1);
    chk("t1_opcode", instr_opcode, 8'h12);
    chk("t1_operand", instr_operand, 8'h00);
    chk("t1_hold_req", {7'd0, mem_req}, 8'h0);
    chk("t1_hold_inc", {7'd0, pc_inc}, 8'h0);
    instr_ready = 1'b1;
    tick();
    chk("t1_drop", {7'd0, instr_valid}, 8'h0);

    // 2: two-byte instruction
    instr_ready = 1'b0; pc = 8'h10; mem_rdata = 8'h85; mem_ack = 1'b1; #1;
    chk("t2_inc_op", {7'd0, pc_inc}, 8'h1);
    tick();
    pc = 8'h11; mem_rdata = 8'h3C; #1;
    chk("t2_arg_req", {7'd0, mem_req}, 8'h1);
    chk("t2_arg_inc", {7'd0, pc_inc}, 8'h1);
    chk("t2_arg_addr", mem_addr, 8'h11);
    chk("t2_arg_valid", {7'd0, instr_valid}, 8'h0);
    chk("t2_arg_opcode", instr_opcode, 8'h85);
    tick();
    pc = 8'h12; #1;
    chk("t2_valid", {7'd0, instr_valid}, 8'h1);
    chk("t2_opcode", instr_opcode, 8'h85);
    chk("t2_operand", instr_operand, 8'h3C);
    chk("t2_hold_req", {7'd0, mem_req}, 8'h0);
    instr_ready = 1'b1;
    tick();

    // 3: three wait cycles, halt raised mid-wait must not withdraw the request
    instr_ready = 1'b0; pc = 8'h20; mem_rdata = 8'h01; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) halt = 1'b1;
      #1;
      chk("t3_wait_req", {7'd0, mem_req}, 8'h1);
      chk("t3_wait_inc", {7'd0, pc_inc}, 8'h0);
      chk("t3_wait_addr", mem_addr, 8'h20);
      tick();
    end
    mem_ack = 1'b1; #1;
    chk("t3_ack_inc", {7'd0, pc_inc}, 8'h1);
    tick();
    halt = 1'b0; pc = 8'h21; #1;
    chk("t3_valid", {7'd0, instr_valid}, 8'h1);
    chk("t3_opcode", instr_opcode, 8'h01);

    // 4: decoder stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_valid", {7'd0, instr_valid}, 8'h1);
      chk("t4_opcode", instr_opcode, 8'h01);
      chk("t4_req", {7'd0, mem_req}, 8'h0);
      chk("t4_inc", {7'd0, pc_inc}, 8'h0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; mem_rdata = 8'h02; #1;
    chk("t4_next_req", {7'd0, mem_req}, 8'h1);
    tick();
    chk("t4_next_opcode", instr_opcode, 8'h02);
    instr_ready = 1'b1;
    tick();

    // 5: flush during operand fetch
    instr_ready = 1'b0; pc = 8'h30; mem_rdata = 8'h90; mem_ack = 1'b1;
    tick();
    pc = 8'h31; mem_rdata = 8'h55; flush = 1'b1; #1;
    chk("t5_flush_req", {7'd0, mem_req}, 8'h0);
    chk("t5_flush_inc", {7'd0, pc_inc}, 8'h0);
    tick();
    flush = 1'b0; pc = 8'h40; mem_ack = 1'b0; #1;
    chk("t5_valid", {7'd0, instr_valid}, 8'h0);
    chk("t5_opcode_kept", instr_opcode, 8'h90);
    chk("t5_refetch_req", {7'd0, mem_req}, 8'h1);
    chk("t5_refetch_addr", mem_addr, 8'h40);
    mem_rdata = 8'h07; mem_ack = 1'b1; #1;
    chk("t5_refetch_inc", {7'd0, pc_inc}, 8'h1);
    tick();
    chk("t5_new_valid", {7'd0, instr_valid}, 8'h1);
    chk("t5_new_opcode", instr_opcode, 8'h07);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // 6: halt blocks fetch, then async reset in the middle of an operand fetch
    halt = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_halt_req", {7'd0, mem_req}, 8'h0);
      chk("t6_halt_inc", {7'd0, pc_inc}, 8'h0);
      tick();
    end
    halt = 1'b0; pc = 8'h50; mem_rdata = 8'h81;
    tick();
    mem_ack = 1'b0; pc = 8'h51; #1;
    chk("t6_arg_req", {7'd0, mem_req}, 8'h1);
    chk("t6_arg_opcode", instr_opcode, 8'h81);
    reset = 1'b1; pc = 8'h00; #1;
    chk("t6_rst_req", {7'd0, mem_req}, 8'h0);
    chk("t6_rst_inc", {7'd0, pc_inc}, 8'h0);
    chk("t6_rst_valid", {7'd0, instr_valid}, 8'h0);
    chk("t6_rst_opcode", instr_opcode, 8'h00);
    chk("t6_rst_operand", instr_operand, 8'h00);
    chk("t6_rst_addr", mem_addr, 8'h00);
    halt = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_post_valid", {7'd0, instr_valid}, 8'h0);
    chk("t6_post_req", {7'd0, mem_req}, 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
